// File: rtl/cnn_mac_pkg.sv
// ----------------------------------------------------------------------------
// cnn_mac_pkg
//   Shared definitions for the pipelined signed MAC used in the CNN conv
//   datapath: default widths, the saturation result record and the clamp
//   helper used on the output path.
// ----------------------------------------------------------------------------
package cnn_mac_pkg;

   localparam int unsigned A_W_DEF       = 14;
   localparam int unsigned B_W_DEF       = 8;
   localparam int unsigned PROD_W_DEF    = A_W_DEF + B_W_DEF;
   localparam int unsigned NUM_STAGE_DEF = 2;
   localparam int unsigned ACC_W_DEF     = 32;
   localparam int unsigned OUT_W_DEF     = 22;

   // Clamp result: sat flags that value was pulled in to the OUT_W range.
   // value is kept at full 64-bit width; callers take the low OUT_W bits.
   typedef struct packed {
      logic        sat;
      logic [63:0] value;
   } sat_res_t;

   // Clamp a signed sum to the signed range of an out_w-bit word.
   function automatic sat_res_t sat_clamp(input logic signed [63:0] sum,
                                          input int unsigned        out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t           r;
      hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo      = -(64'sd1 <<< (out_w - 1));
      r.sat   = 1'b0;
      r.value = sum;
      if (sum > hi) begin
         r.sat   = 1'b1;
         r.value = hi;
      end else if (sum < lo) begin
         r.sat   = 1'b1;
         r.value = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/cnn_mac_pipe_sat_mul.sv
// ----------------------------------------------------------------------------
// cnn_mac_mul_pipe
//   NUM_STAGE-deep signed multiplier. The product is registered straight after
//   the multiply and then shifted along NUM_STAGE-1 further registers so the
//   whole chain can pack into a DSP48 (M/P registers). A valid bit and the
//   packet-last bit travel alongside the product.
//
// Ports
//   clk        clock, rising edge
//   rst_n      async active-low reset (clears the valid sideband only)
//   en         advance the pipeline; when low every stage holds
//   din_a      signed operand A (A_W)
//   din_b      signed operand B (B_W)
//   in_vld     beat valid entering stage 0
//   in_last    beat closes a packet
//   prod       signed product at the last stage (A_W+B_W)
//   prod_vld   valid bit at the last stage
//   prod_last  last bit at the last stage
// ----------------------------------------------------------------------------
module cnn_mac_mul_pipe
   import cnn_mac_pkg::*;
#(
   parameter  int unsigned A_W       = A_W_DEF,
   parameter  int unsigned B_W       = B_W_DEF,
   parameter  int unsigned NUM_STAGE = NUM_STAGE_DEF,
   localparam int unsigned PROD_W    = A_W + B_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic signed [A_W-1:0]    din_a,
   input  logic signed [B_W-1:0]    din_b,
   input  logic                     in_vld,
   input  logic                     in_last,
   output logic signed [PROD_W-1:0] prod,
   output logic                     prod_vld,
   output logic                     prod_last
);

   logic signed [PROD_W-1:0] p_q [NUM_STAGE];
   logic [NUM_STAGE-1:0]     v_q;
   logic [NUM_STAGE-1:0]     l_q;

   // Data registers carry no reset so they map onto the DSP pipeline
   // registers; the valid sideband alone decides whether they mean anything.
   always_ff @(posedge clk) begin
      if (en) begin
         p_q[0] <= din_a * din_b;
         for (int unsigned i = 1; i < NUM_STAGE; i++) begin
            p_q[i] <= p_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         l_q <= '0;
      end else if (en) begin
         v_q[0] <= in_vld;
         l_q[0] <= in_last;
         for (int unsigned i = 1; i < NUM_STAGE; i++) begin
            v_q[i] <= v_q[i-1];
            l_q[i] <= l_q[i-1];
         end
      end
   end

   assign prod      = p_q[NUM_STAGE-1];
   assign prod_vld  = v_q[NUM_STAGE-1];
   assign prod_last = l_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe_sat.sv
// ----------------------------------------------------------------------------
// cnn_mac_pipe_sat
//   Pipelined signed multiply-accumulate between the weight/feature-map
//   buffers and the conv output store. Products are summed per packet
//   (in_last closes a dot product) or emitted one by one, and the result is
//   optionally clamped to the signed OUT_W range.
//
// Ports
//   ap_clk    clock, rising edge
//   ap_rst_n  async active-low reset
//   din0      signed operand A (feature, A_W)
//   din1      signed operand B (weight, B_W)
//   in_vld    operand beat valid
//   in_last   beat is the last of its packet (ignored when ACC_EN=0)
//   in_rdy    unit accepts a beat this cycle
//   dout      signed result (OUT_W)
//   out_vld   dout valid
//   out_rdy   downstream accepts dout
//   out_sat   dout was clamped (qualified by out_vld)
//
// Latency from accepted last beat to out_vld is NUM_STAGE+1 cycles; one beat
// per cycle with back-to-back packets. A held output stalls the whole unit.
// ----------------------------------------------------------------------------
module cnn_mac_pipe_sat
   import cnn_mac_pkg::*;
#(
   parameter int unsigned A_W       = A_W_DEF,
   parameter int unsigned B_W       = B_W_DEF,
   parameter int unsigned NUM_STAGE = NUM_STAGE_DEF,
   parameter int unsigned ACC_W     = ACC_W_DEF,
   parameter int unsigned OUT_W     = OUT_W_DEF,
   parameter bit          ACC_EN    = 1'b1,
   parameter bit          SAT_EN    = 1'b1
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic signed [A_W-1:0]   din0,
   input  logic signed [B_W-1:0]   din1,
   input  logic                    in_vld,
   input  logic                    in_last,
   output logic                    in_rdy,
   output logic signed [OUT_W-1:0] dout,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic                    out_sat
);

   localparam int unsigned PROD_W = A_W + B_W;

   logic                    stall;
   logic                    pipe_en;
   logic signed [PROD_W-1:0] prod;
   logic                    prod_vld;
   logic                    prod_last;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum;
   logic                    emit;
   sat_res_t                clamp;
   logic [OUT_W-1:0]        dout_d;
   logic                    sat_d;
   logic                    unused_clamp_hi;

   // A result waiting on downstream freezes every stage, so nothing in flight
   // can overtake or overwrite it.
   assign stall   = out_vld & ~out_rdy;
   assign in_rdy  = ~stall;
   assign pipe_en = ~stall;

   cnn_mac_mul_pipe #(
      .A_W       (A_W),
      .B_W       (B_W),
      .NUM_STAGE (NUM_STAGE)
   ) u_mul (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .en        (pipe_en),
      .din_a     (din0),
      .din_b     (din1),
      .in_vld    (in_vld),
      .in_last   (in_last),
      .prod      (prod),
      .prod_vld  (prod_vld),
      .prod_last (prod_last)
   );

   always_comb begin
      prod_ext = ACC_W'(prod);
      sum      = ACC_EN ? (acc + prod_ext) : prod_ext;
      emit     = prod_vld & (~ACC_EN | prod_last);
      clamp    = sat_clamp(64'(sum), OUT_W);
      if (SAT_EN) begin
         dout_d = clamp.value[OUT_W-1:0];
         sat_d  = clamp.sat;
      end else begin
         dout_d = sum[OUT_W-1:0];
         sat_d  = 1'b0;
      end
   end

   // Upper clamp bits are sign copies of dout_d and are deliberately dropped.
   assign unused_clamp_hi = ^(clamp.value >> OUT_W);

   // Accumulator and output register. Outside a stall out_vld is either
   // already low or being handshaked, so it simply follows emit; a new result
   // may replace the one accepted in the same cycle.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc     <= '0;
         out_vld <= 1'b0;
         dout    <= '0;
         out_sat <= 1'b0;
      end else if (!stall) begin
         if (emit) begin
            acc     <= '0;
            out_vld <= 1'b1;
            dout    <= dout_d;
            out_sat <= sat_d;
         end else begin
            out_vld <= 1'b0;
            if (prod_vld) begin
               acc <= sum;
            end
         end
      end
   end

endmodule
